lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit between the RV32I execute stage and dmem. Accepts one load/store
//  request per valid/ready handshake and drives dmem's byte address, write data and byte mask.
//  Loads: samples dmem's combinational rdata, then extracts and sign/zero-extends per funct3.
//  Checks each request for illegal size, misalignment and out-of-range access, and returns a fault code.
// PARAMETERS
//  DMEM_BYTES        16384  dmem size in bytes; an access with last byte >= DMEM_BYTES faults
//  ALLOW_MISALIGNED  1      1: pass misaligned H/W accesses to dmem (dmem is byte-granular); 0: fault
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  rst           in   1   reset, synchronous, active-high
//  req_valid     in   1   request present
//  req_ready     out  1   request accepted this cycle when req_valid&&req_ready
//  req_we        in   1   1=store, 0=load
//  req_funct3    in   3   RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-justified
//  resp_valid    out  1   response held until resp_ready
//  resp_ready    in   1   consumer accepts response
//  resp_rdata    out  32  extended load data; 0 for stores and faults
//  resp_fault    out  2   00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3
//  mem_we        out  1   dmem write enable
//  mem_wmask     out  4   dmem byte mask; bit i = byte at mem_addr+i
//  mem_addr      out  32  dmem byte address (unaligned, byte-granular)
//  mem_wdata     out  32  dmem write data, byte i = wdata[8i+7:8i], not shifted
//  mem_rdata     in   32  dmem read data; byte i = mem[mem_addr+i]
// BEHAVIOUR
//  - FSM: IDLE -> EXEC -> RESP -> IDLE.
//    - IDLE: req_ready=1. On accept, register we/funct3/addr/wdata and go to EXEC.
//    - EXEC: one cycle. Drive mem_*; capture the load result and fault code; go to RESP.
//    - RESP: resp_valid=1. When resp_ready, go to IDLE. req_ready=0 in EXEC and RESP.
//  - Latency: accepted at edge N; EXEC during cycle N+1; resp_valid from N+2; max 1 req / 3 cycles.
//  - Size from funct3[1:0]: 00=1 B, 01=2 B, 10=4 B.
//  - Illegal funct3: loads 011/110/111; stores funct3[2]=1 or 011.
//  - Misaligned: H with addr[0]!=0, or W with addr[1:0]!=0, when ALLOW_MISALIGNED=0.
//  - Range: addr+size-1 >= DMEM_BYTES, computed 33-bit so wrap past 2^32 also faults.
//  - Fault priority: illegal > misaligned > range. A faulting store never asserts mem_we.
//  - mem_we = (state==EXEC) && store && !fault && !rst. A same-edge reset suppresses the write.
//  - mem_wmask: store-only, EXEC only; SB=0001, SH=0011, SW=1111. 0000 otherwise.
//  - mem_addr = registered addr in all states; mem_wdata = registered wdata when store, else 0.
//  - Load extract from mem_rdata in EXEC:
//    - LB: sext [7:0]; LBU: zext [7:0]; LH: sext [15:0]; LHU: zext [15:0]; LW: [31:0].
//  - resp_rdata/resp_fault are registered and stable while resp_valid && !resp_ready.
//  - Reset: state=IDLE; req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_fault=00;
//    mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0. Reset in EXEC/RESP drops the request.
//  - req_valid while not ready is ignored; the requester holds it.
// STRUCTURE
//  - Package lsu_pkg:
//    - funct3 constants F3_B/H/W/BU/HU;
//    - fault codes FLT_NONE/MISAL/RANGE/ILLEGAL;
//    - state encoding ST_IDLE/EXEC/RESP.
//  - Sub-module lsu_load_ext: combinational (funct3, rdata) -> extended 32-bit load data.
//  - Top holds FSM, request/response registers, and fault check logic.
// TESTING (bench instantiates lsu_ctrl + dmem, rom.hex zeroed)
//  - SW 0xDEADBEEF @0x100 then LW @0x100 -> mem_wmask=1111 one cycle; resp_rdata=0xDEADBEEF, fault 00
//  - SB 0x80 @0x203 then LB/LBU @0x203 -> 0xFFFFFF80 / 0x00000080; LH @0x202 -> 0xFFFF8000
//  - SH @0x101, ALLOW_MISALIGNED=1: write ok, LHU reads back. With =0: fault 01, mem_we never 1
//  - LW @0x3FFD with DMEM_BYTES=16384 -> fault 10, rdata 0; SW @0xFFFFFFFE -> fault 10, no write
//  - Load funct3=011 -> fault 11. Hold resp_ready=0 5 cycles -> resp stable, req_ready=0 throughout
//  - Assert rst in the store's EXEC cycle -> mem_we=0, target byte unchanged, FSM back to IDLE

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 decodes, fault codes, FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_MISAL   = 2'b01;
  localparam logic [1:0] FLT_RANGE   = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Access width in bytes from funct3[1:0]; the 11 encoding is illegal and faults before use.
  function automatic logic [2:0] access_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Extracts and sign/zero-extends load data from the dmem read word.
// Latency: combinational. Backpressure: none.
// Backpressure: not applicable, pure function of its inputs.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{rdata[7]}}, rdata[7:0]};
      F3_H:    data = {{16{rdata[15]}}, rdata[15:0]};
      F3_W:    data = rdata;
      F3_BU:   data = {24'b0, rdata[7:0]};
      F3_HU:   data = {16'b0, rdata[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store unit: one request in, dmem access in EXEC, fault-checked response out.
// Latency: accept at edge N, dmem access in cycle N+1, resp_valid from N+2; one request per 3 cycles.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES       = 16384,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  logic [1:0]  state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [2:0]  size;
  logic [32:0] last_byte;
  logic        illegal;
  logic        misal;
  logic        out_of_range;
  logic [1:0]  fault;
  logic [3:0]  size_mask;
  logic [31:0] load_data;

  assign size = access_bytes(r_funct3[1:0]);

  // 33-bit sum so an access wrapping past 2^32 still lands out of range.
  assign last_byte    = {1'b0, r_addr} + {30'b0, size} - 33'd1;
  assign out_of_range = last_byte >= 33'(DMEM_BYTES);

  always_comb begin
    if (r_we) illegal = r_funct3[2] || (r_funct3[1:0] == 2'b11);
    else      illegal = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) || (r_funct3 == 3'b111);
  end

  assign misal = !ALLOW_MISALIGNED &&
                 (((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                  ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00)));

  always_comb begin
    fault = FLT_NONE;
    if (illegal)           fault = FLT_ILLEGAL;
    else if (misal)        fault = FLT_MISAL;
    else if (out_of_range) fault = FLT_RANGE;
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  lsu_load_ext u_load_ext (
    .funct3 (r_funct3),
    .rdata  (mem_rdata),
    .data   (load_data)
  );

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  // rst gates the write combinationally so a reset landing on the EXEC edge drops the store.
  assign mem_we    = (state == ST_EXEC) && r_we && (fault == FLT_NONE) && !rst;
  assign mem_wmask = ((state == ST_EXEC) && r_we) ? size_mask : 4'b0000;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_we ? r_wdata : 32'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      r_we       <= 1'b0;
      r_funct3   <= 3'b0;
      r_addr     <= 32'b0;
      r_wdata    <= 32'b0;
      resp_rdata <= 32'b0;
      resp_fault <= FLT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_fault <= fault;
          resp_rdata <= (!r_we && (fault == FLT_NONE)) ? load_data : 32'b0;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
